// File: rtl/vme_cycle_master.sv
// ---------------------------------------------------------------------------
// vme_cycle_master
//
// Executes one VME single-word bus cycle per command word. A command is taken
// from start/vme_cmd_reg/vme_dat_reg_in while vme_cmd_rd is high. The block
// then drives address, address modifier and (for writes) data through a setup
// phase, asserts the strobes, waits for the slave to acknowledge (or signal a
// bus error, or time out), releases the strobes, waits for the slave to let go,
// and finally reports status plus read data on vme_dat_reg_out with a
// one-cycle vme_dat_wr pulse.
//
// Ports:
//   clk, rst_n        clock; synchronous active-low reset
//   start             command valid, taken only while vme_cmd_rd=1
//   vme_cmd_reg       [15:0] offset, [23:16] board, [24] write, [25] read
//   vme_dat_reg_in    write data, low 16 bits used
//   vme_cmd_rd        ready for a command (IDLE)
//   vme_dat_wr        one-cycle result strobe
//   vme_dat_reg_out   [31] timeout, [30] bus error, [29] illegal, [15:0] data
//   vme_addr/vme_am   bus address and address modifier
//   vme_data_out/oe   bus write data and its output enable
//   vme_data_in       bus read data
//   vme_write_b       bus direction, low for writes
//   vme_as_b/vme_ds_b address and data strobes, active low
//   vme_dtack_b       slave acknowledge, asynchronous, active low
//   vme_berr_b        bus error, asynchronous, active low
// ---------------------------------------------------------------------------
module vme_cycle_master #(
    parameter int unsigned SETUP_CYC = 2,
    parameter int unsigned TIMEOUT   = 255,
    parameter logic [5:0]  AM        = 6'h39
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] vme_cmd_reg,
    input  logic [31:0] vme_dat_reg_in,
    output logic        vme_cmd_rd,
    output logic        vme_dat_wr,
    output logic [31:0] vme_dat_reg_out,
    output logic [23:0] vme_addr,
    output logic [5:0]  vme_am,
    output logic [15:0] vme_data_out,
    output logic        vme_data_oe,
    input  logic [15:0] vme_data_in,
    output logic        vme_write_b,
    output logic        vme_as_b,
    output logic [1:0]  vme_ds_b,
    input  logic        vme_dtack_b,
    input  logic        vme_berr_b
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETUP   = 3'd1,
        STROBE  = 3'd2,
        RELEASE = 3'd3,
        DONE    = 3'd4
    } state_t;

    localparam logic [7:0] SETUP_LAST = 8'(SETUP_CYC - 1);
    localparam logic [7:0] TO_LAST    = 8'(TIMEOUT - 1);

    state_t      state;
    state_t      state_nx;

    logic        dtack_p0;
    logic        dtack_p1;
    logic        berr_p0;
    logic        berr_p1;

    logic [7:0]  cnt;
    logic [7:0]  cnt_nx;
    logic [7:0]  cnt_inc;

    logic        is_write;
    logic        flag_to;
    logic        flag_be;
    logic        flag_il;
    logic [15:0] rdata;

    logic        accept;
    logic        legal_cmd;
    logic        cmd_write;
    logic        set_to;
    logic        set_be;
    logic        cap_rd;
    logic        write_nx;
    logic        flag_to_nx;
    logic        flag_be_nx;
    logic        flag_il_nx;
    logic [15:0] rdata_nx;
    logic        active_nx;
    logic [15:0] result_data;

    // Command bits that carry no meaning for this block.
    logic        unused_bits;
    assign unused_bits = ^{vme_cmd_reg[31:26], vme_dat_reg_in[31:16]};

    // Read wins over write when both direction bits are set.
    assign legal_cmd = vme_cmd_reg[25] | vme_cmd_reg[24];
    assign cmd_write = ~vme_cmd_reg[25] & vme_cmd_reg[24];

    // Wait counter saturates instead of wrapping.
    assign cnt_inc = (cnt == 8'hFF) ? cnt : cnt + 8'd1;

    // ---- stage p0/p1: two-flop synchronizers for the asynchronous slave lines
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dtack_p0 <= 1'b1;
            dtack_p1 <= 1'b1;
            berr_p0  <= 1'b1;
            berr_p1  <= 1'b1;
        end else begin
            dtack_p0 <= vme_dtack_b;
            dtack_p1 <= dtack_p0;
            berr_p0  <= vme_berr_b;
            berr_p1  <= berr_p0;
        end
    end

    // ---- state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= 8'd0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // ---- next-state logic
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        accept   = 1'b0;
        set_to   = 1'b0;
        set_be   = 1'b0;
        cap_rd   = 1'b0;
        case (state)
            IDLE: begin
                cnt_nx = 8'd0;
                if (start) begin
                    accept   = 1'b1;
                    state_nx = legal_cmd ? SETUP : DONE;
                end
            end
            SETUP: begin
                if (cnt == SETUP_LAST) begin
                    state_nx = STROBE;
                    cnt_nx   = 8'd0;
                end else begin
                    cnt_nx = cnt_inc;
                end
            end
            STROBE: begin
                // Bus error is examined first so it dominates a simultaneous ack.
                if (!berr_p1) begin
                    set_be   = 1'b1;
                    state_nx = RELEASE;
                    cnt_nx   = 8'd0;
                end else if (!dtack_p1) begin
                    cap_rd   = ~is_write;
                    state_nx = RELEASE;
                    cnt_nx   = 8'd0;
                end else if (cnt == TO_LAST) begin
                    set_to   = 1'b1;
                    state_nx = RELEASE;
                    cnt_nx   = 8'd0;
                end else begin
                    cnt_nx = cnt_inc;
                end
            end
            RELEASE: begin
                if (dtack_p1 && berr_p1) begin
                    state_nx = DONE;
                    cnt_nx   = 8'd0;
                end else if (cnt == TO_LAST) begin
                    set_to   = 1'b1;
                    state_nx = DONE;
                    cnt_nx   = 8'd0;
                end else begin
                    cnt_nx = cnt_inc;
                end
            end
            DONE: begin
                state_nx = IDLE;
                cnt_nx   = 8'd0;
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = 8'd0;
            end
        endcase
    end

    // Next values of the per-command context; a new command clears it.
    always_comb begin
        write_nx   = accept ? cmd_write  : is_write;
        flag_to_nx = accept ? 1'b0       : (flag_to | set_to);
        flag_be_nx = accept ? 1'b0       : (flag_be | set_be);
        flag_il_nx = accept ? ~legal_cmd : flag_il;
        rdata_nx   = accept ? 16'h0000   : (cap_rd ? vme_data_in : rdata);
        active_nx  = (state_nx == SETUP) || (state_nx == STROBE) ||
                     (state_nx == RELEASE);
        // Any error condition suppresses the data field.
        result_data = (flag_to_nx | flag_be_nx | flag_il_nx) ? 16'h0000 : rdata_nx;
    end

    // ---- output stage: bus and host-side outputs registered from next state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            is_write        <= 1'b0;
            flag_to         <= 1'b0;
            flag_be         <= 1'b0;
            flag_il         <= 1'b0;
            rdata           <= 16'h0000;
            vme_cmd_rd      <= 1'b1;
            vme_dat_wr      <= 1'b0;
            vme_dat_reg_out <= 32'h0000_0000;
            vme_addr        <= 24'h00_0000;
            vme_am          <= 6'h00;
            vme_data_out    <= 16'h0000;
            vme_data_oe     <= 1'b0;
            vme_write_b     <= 1'b1;
            vme_as_b        <= 1'b1;
            vme_ds_b        <= 2'b11;
        end else begin
            is_write <= write_nx;
            flag_to  <= flag_to_nx;
            flag_be  <= flag_be_nx;
            flag_il  <= flag_il_nx;
            rdata    <= rdata_nx;

            if (accept && legal_cmd) begin
                vme_addr     <= vme_cmd_reg[23:0];
                vme_data_out <= cmd_write ? vme_dat_reg_in[15:0] : 16'h0000;
            end

            vme_cmd_rd  <= (state_nx == IDLE);
            vme_dat_wr  <= (state_nx == DONE);
            vme_am      <= active_nx ? AM : 6'h00;
            vme_data_oe <= active_nx & write_nx;
            vme_write_b <= ~(active_nx & write_nx);
            vme_as_b    <= (state_nx != STROBE);
            vme_ds_b    <= {2{state_nx != STROBE}};

            if (state_nx == DONE) begin
                vme_dat_reg_out <= {flag_to_nx, flag_be_nx, flag_il_nx, 13'h0000,
                                    result_data};
            end
        end
    end

endmodule

// File: tb/tb_vme_cycle_master.sv
// ---------------------------------------------------------------------------
// tb_vme_cycle_master
//
// Directed bench for vme_cycle_master with default parameters
// (SETUP_CYC=2, TIMEOUT=255, AM=6'h39). A small behavioural slave acks a
// configurable number of cycles after the address strobe falls and releases
// when the strobe rises; a monitor counts strobe-low cycles, result pulses and
// direction/enable activity over each transaction.
// ---------------------------------------------------------------------------
module tb_vme_cycle_master;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] vme_cmd_reg;
    logic [31:0] vme_dat_reg_in;
    logic        vme_cmd_rd;
    logic        vme_dat_wr;
    logic [31:0] vme_dat_reg_out;
    logic [23:0] vme_addr;
    logic [5:0]  vme_am;
    logic [15:0] vme_data_out;
    logic        vme_data_oe;
    logic [15:0] vme_data_in;
    logic        vme_write_b;
    logic        vme_as_b;
    logic [1:0]  vme_ds_b;
    logic        vme_dtack_b;
    logic        vme_berr_b;

    always #5 clk = ~clk;

    vme_cycle_master dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .vme_cmd_reg     (vme_cmd_reg),
        .vme_dat_reg_in  (vme_dat_reg_in),
        .vme_cmd_rd      (vme_cmd_rd),
        .vme_dat_wr      (vme_dat_wr),
        .vme_dat_reg_out (vme_dat_reg_out),
        .vme_addr        (vme_addr),
        .vme_am          (vme_am),
        .vme_data_out    (vme_data_out),
        .vme_data_oe     (vme_data_oe),
        .vme_data_in     (vme_data_in),
        .vme_write_b     (vme_write_b),
        .vme_as_b        (vme_as_b),
        .vme_ds_b        (vme_ds_b),
        .vme_dtack_b     (vme_dtack_b),
        .vme_berr_b      (vme_berr_b)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=0x%08h want=0x%08h", tag, got, want);
        end
    endtask

    // Slave model
    logic        slave_en   = 1'b0;
    logic        berr_mode  = 1'b0;
    int          dly        = 3;
    logic [15:0] slave_data = 16'h0000;

    initial begin
        int as_cnt;
        as_cnt      = 0;
        vme_dtack_b = 1'b1;
        vme_berr_b  = 1'b1;
        vme_data_in = 16'h0000;
        forever begin
            @(negedge clk);
            if (slave_en && !vme_as_b) begin
                if (as_cnt >= dly) begin
                    if (berr_mode) vme_berr_b = 1'b0;
                    vme_dtack_b = 1'b0;
                    vme_data_in = slave_data;
                end
                as_cnt++;
            end else begin
                as_cnt      = 0;
                vme_dtack_b = 1'b1;
                vme_berr_b  = 1'b1;
                vme_data_in = 16'h0000;
            end
        end
    end

    // Monitor
    int wr_pulses = 0;
    int as_low    = 0;
    int oe_seen   = 0;
    int wrb_low   = 0;

    always @(negedge clk) begin
        if (vme_dat_wr)   wr_pulses++;
        if (!vme_as_b)    as_low++;
        if (vme_data_oe)  oe_seen++;
        if (!vme_write_b) wrb_low++;
    end

    task automatic clear_mon();
        wr_pulses = 0;
        as_low    = 0;
        oe_seen   = 0;
        wrb_low   = 0;
    endtask

    // Leaves the bench #1 after the accept edge, i.e. in cycle T+1.
    task automatic issue(input logic [31:0] c, input logic [31:0] d);
        int n;
        n = 0;
        while (!vme_cmd_rd && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        chk_eq("ready_before_cmd", vme_cmd_rd, 1);
        vme_cmd_reg    = c;
        vme_dat_reg_in = d;
        start          = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Counts cycles after the accept edge until vme_dat_wr is seen.
    task automatic wait_done(input int from, output int lat);
        lat = from;
        while (!vme_dat_wr && lat < 1000) begin
            @(posedge clk); #1;
            lat++;
        end
        chk_eq("dat_wr_seen", vme_dat_wr, 1);
    endtask

    initial begin
        int lat;
        int n;
        rst_n          = 1'b0;
        start          = 1'b0;
        vme_cmd_reg    = 32'h0;
        vme_dat_reg_in = 32'h0;
        repeat (3) @(posedge clk);
        #1;

        // Reset state
        chk_eq("rst_cmd_rd",  vme_cmd_rd, 1);
        chk_eq("rst_dat_wr",  vme_dat_wr, 0);
        chk_eq("rst_dat_out", vme_dat_reg_out, 32'h0);
        chk_eq("rst_addr_am", {2'b00, vme_am, vme_addr}, 32'h0);
        chk_eq("rst_data",    {vme_data_oe, vme_data_out}, 32'h0);
        chk_eq("rst_ctl",     {vme_write_b, vme_as_b, vme_ds_b}, 32'hF);

        rst_n = 1'b1;
        @(posedge clk); #1;

        // Write: DTACK three cycles into the strobe
        slave_en = 1'b1; berr_mode = 1'b0; dly = 3; slave_data = 16'hDEAD;
        clear_mon();
        issue(32'h01A8_4020, 32'h0000_BEEF);
        chk_eq("wr_cmd_rd_low", vme_cmd_rd, 0);
        chk_eq("wr_addr",       vme_addr, 32'h00A8_4020);
        chk_eq("wr_am",         vme_am, 32'h39);
        chk_eq("wr_write_b",    vme_write_b, 0);
        chk_eq("wr_data_out",   vme_data_out, 32'hBEEF);
        chk_eq("wr_data_oe",    vme_data_oe, 1);
        chk_eq("wr_setup1_as",  vme_as_b, 1);
        @(posedge clk); #1;
        chk_eq("wr_setup2_as",  vme_as_b, 1);
        @(posedge clk); #1;
        chk_eq("wr_strobe",     {vme_as_b, vme_ds_b}, 0);
        wait_done(3, lat);
        chk_eq("wr_latency",    lat, 12);
        chk_eq("wr_result",     vme_dat_reg_out, 32'h0);
        @(posedge clk); #1;
        chk_eq("wr_pulse_end",  vme_dat_wr, 0);
        chk_eq("wr_ready",      vme_cmd_rd, 1);
        chk_eq("wr_pulses",     wr_pulses, 1);
        chk_eq("wr_as_cycles",  as_low, 6);
        chk_eq("wr_am_idle",    vme_am, 0);

        // Read returning 0x1234
        slave_data = 16'h1234;
        clear_mon();
        issue(32'h02A8_4100, 32'h0000_FFFF);
        chk_eq("rd_addr",       vme_addr, 32'h00A8_4100);
        wait_done(1, lat);
        chk_eq("rd_latency",    lat, 12);
        chk_eq("rd_result",     vme_dat_reg_out, 32'h0000_1234);
        @(posedge clk); #1;
        chk_eq("rd_write_b_lo", wrb_low, 0);
        chk_eq("rd_oe_seen",    oe_seen, 0);
        chk_eq("rd_pulses",     wr_pulses, 1);

        // Read with no acknowledge: timeout
        slave_en = 1'b0;
        clear_mon();
        issue(32'h02A8_4100, 32'h0);
        wait_done(1, lat);
        chk_eq("to_result",     vme_dat_reg_out, 32'h8000_0000);
        chk_eq("to_as_cycles",  as_low, 255);
        chk_eq("to_latency",    lat, 259);
        @(posedge clk); #1;

        // BERR and DTACK fall together
        slave_en = 1'b1; berr_mode = 1'b1; slave_data = 16'h5555;
        clear_mon();
        issue(32'h02A8_4100, 32'h0);
        wait_done(1, lat);
        chk_eq("berr_result",   vme_dat_reg_out, 32'h4000_0000);
        @(posedge clk); #1;
        berr_mode = 1'b0;

        // Illegal command: no bus activity
        clear_mon();
        issue(32'h00A8_0000, 32'h0);
        chk_eq("ill_dat_wr",    vme_dat_wr, 1);
        chk_eq("ill_result",    vme_dat_reg_out, 32'h2000_0000);
        chk_eq("ill_cmd_rd",    vme_cmd_rd, 0);
        @(posedge clk); #1;
        chk_eq("ill_ready",     vme_cmd_rd, 1);
        chk_eq("ill_pulse_end", vme_dat_wr, 0);
        chk_eq("ill_as_cycles", as_low, 0);

        // Reset while strobes are asserted
        slave_en = 1'b0;
        clear_mon();
        issue(32'h02A8_4100, 32'h0);
        n = 0;
        while (vme_as_b && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk_eq("rst_mid_strobe", vme_as_b, 0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk_eq("rst_mid_strb",  {vme_as_b, vme_ds_b}, 32'h7);
        chk_eq("rst_mid_rd",    vme_cmd_rd, 1);
        chk_eq("rst_mid_wr",    vme_dat_wr, 0);
        rst_n = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
        end
        chk_eq("rst_no_pulse",  wr_pulses, 0);

        // Write after reset completes normally
        slave_en = 1'b1;
        clear_mon();
        issue(32'h0112_3456, 32'h0000_CAFE);
        chk_eq("pw_addr",       vme_addr, 32'h0012_3456);
        chk_eq("pw_data_out",   vme_data_out, 32'hCAFE);
        wait_done(1, lat);
        chk_eq("pw_latency",    lat, 12);
        chk_eq("pw_result",     vme_dat_reg_out, 32'h0);
        @(posedge clk); #1;
        chk_eq("pw_pulses",     wr_pulses, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vme_cycle_master.md
# vme_cycle_master

Bus-cycle sequencer that consumes 32-bit command words (start / vme_cmd_reg / vme_dat_reg_in) from the test-bench command source. For each word it executes one VME single-word cycle against the ODMB VME slave. Read data and status return on vme_dat_reg_out with a one-cycle vme_dat_wr pulse. It signals readiness for the next command on vme_cmd_rd, closing the command loop.

## Interface
Parameters:
- SETUP_CYC, 2 — cycles of address/data setup before strobes assert (1..15)
- TIMEOUT, 255 — max cycles waiting on each DTACK edge before abort (1..255)
- AM, 6'h39 — address modifier driven during every cycle

Ports:
- clk  in  1  system clock; single clock domain
- rst_n  in  1  synchronous, active-low reset
- start  in  1  command valid; sampled only when vme_cmd_rd=1
- vme_cmd_reg  in  32  [15:0] VME address offset, [23:16] board select, [24] write, [25] read
- vme_dat_reg_in  in  32  write data; [15:0] used
- vme_cmd_rd  out  1  ready for a command (high only in IDLE)
- vme_dat_wr  out  1  one-cycle pulse: result valid on vme_dat_reg_out
- vme_dat_reg_out  out  32  [31] timeout, [30] bus error, [29] illegal cmd, [28:16] zero, [15:0] read data (0 for writes/errors)
- vme_addr  out  24  {board select, offset}, held for whole cycle
- vme_am  out  6  = AM while cycle active, 0 in IDLE
- vme_data_out  out  16  write data, held SETUP..RELEASE
- vme_data_oe  out  1  high during write cycle SETUP..RELEASE
- vme_data_in  in  16  slave read data
- vme_write_b  out  1  low for write cycles
- vme_as_b  out  1  address strobe, active low
- vme_ds_b  out  2  data strobes, active low, both driven together
- vme_dtack_b  in  1  slave acknowledge, active low, asynchronous
- vme_berr_b  in  1  bus error, active low, asynchronous

## Operation
- dtack_b/berr_b pass through 2-FF synchronizers; all decisions use synchronized versions.
- States: IDLE, SETUP, STROBE, RELEASE, DONE.
- IDLE: vme_cmd_rd=1. On start=1, latch command and data, then:
  - bit25=1 → read (bit25 wins if bits 24 and 25 both set).
  - Else bit24=1 → write.
  - Neither set → skip bus; go to DONE with status[29]=1.
- SETUP: drive vme_addr, vme_am, vme_write_b, vme_data_out/oe. Strobes high. Count SETUP_CYC cycles → STROBE.
- STROBE: as_b=0, ds_b=2'b00. Wait cycle counter runs.
  - Sync dtack=0 → capture vme_data_in (reads) → RELEASE.
  - Sync berr=0 → status[30]=1 → RELEASE. Checked before dtack; berr wins if both fall together.
  - Counter reaches TIMEOUT → status[31]=1 → RELEASE.
- RELEASE: as_b, ds_b high. Wait for sync dtack=1 and sync berr=1. Counter restarts; second timeout also sets [31] → DONE.
- DONE: vme_dat_wr=1 for exactly one cycle. vme_dat_reg_out updated same cycle and held until next DONE. → IDLE.
- start while not in IDLE is ignored; no queueing.

## Timing
- Reset (rst_n=0 at clk edge):
  - state IDLE, vme_cmd_rd=1, vme_dat_wr=0, vme_dat_reg_out=0
  - vme_addr=0, vme_am=0, vme_data_out=0, vme_data_oe=0
  - vme_write_b=1, vme_as_b=1, vme_ds_b=2'b11, counters and synchronizers cleared
- Reset mid-cycle releases strobes on the next edge. No vme_dat_wr is issued for the aborted command.
- Accept at edge T; vme_cmd_rd=0 from T+1.
- Strobes low at T+1+SETUP_CYC.
- If dtack_b falls in cycle D, synchronized low at D+2 → strobes high at D+3.
- vme_dat_wr asserts one cycle after sync dtack is observed high.
- vme_cmd_rd returns high the cycle after vme_dat_wr.
- Illegal command: vme_dat_wr at T+1, vme_cmd_rd high at T+2.
- Timeout counter is 8 bits and saturates; it never wraps.

## Test plan
- Write: cmd 0x01A84020, data 0x0000BEEF, slave DTACK after 3 cycles → vme_addr=0xA84020, write_b=0, data_out=0xBEEF; vme_dat_wr once; dat_reg_out=0x00000000.
- Read: cmd 0x02A84100, slave returns 0x1234 with DTACK → dat_reg_out=0x00001234; write_b=1, data_oe=0 throughout.
- No DTACK on read with TIMEOUT=255 → strobes release after 255 STROBE cycles; dat_reg_out=0x80000000.
- BERR and DTACK fall in the same cycle → dat_reg_out[30]=1, [31]=0; read data ignored.
- cmd 0x00A80000, start=1 → no strobes; dat_reg_out=0x20000000; vme_dat_wr at T+1.
- rst_n low during STROBE → next edge as_b=1, ds_b=11, vme_cmd_rd=1; no vme_dat_wr. A new write afterward completes normally.
